// File: rtl/fifo_flex_if.sv
// Ready/valid bundle between a producer, fifo_flex and a consumer.
// The FIFO side takes the slave modport; the bench/parent drives master.
interface fifo_flex_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();
  logic             p2f_irdy;
  logic [WIDTH-1:0] data_in;
  logic             f2p_trdy;
  logic             f2c_irdy;
  logic [WIDTH-1:0] data_out;
  logic             c2f_trdy;
  logic             flush;
  logic [CNT_W-1:0] count;
  logic             almost_full;
  logic             almost_empty;

  modport master (
    output p2f_irdy, data_in, c2f_trdy, flush,
    input  f2p_trdy, f2c_irdy, data_out,
    input  count, almost_full, almost_empty
  );

  modport slave (
    input  p2f_irdy, data_in, c2f_trdy, flush,
    output f2p_trdy, f2c_irdy, data_out,
    output count, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_flex.sv
// Parametrised ready/valid FIFO with occupancy count,
// almost-full/almost-empty flags and synchronous flush.
module fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  fifo_flex_if.slave bus
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_flex: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_flex: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flex: AE_THRESH out of range 0..DEPTH-1");
  end

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE_P  = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic full, empty, enq, deq;

  // Status depends only on the registered count, never on handshakes.
  assign full  = (count_q == FULL_C);
  assign empty = (count_q == '0);
  assign enq   = bus.p2f_irdy & ~full;
  assign deq   = bus.c2f_trdy & ~empty;

  assign bus.f2p_trdy     = ~full;
  assign bus.f2c_irdy     = ~empty;
  assign bus.data_out     = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count        = count_q;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq) begin
        wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + ONE_P;
      end
      if (deq) begin
        rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + ONE_P;
      end
      unique case ({enq, deq})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage holds no reset; stale entries are unreachable via the pointers.
  always_ff @(posedge clk) begin
    if (enq && !bus.flush) begin
      mem_q[wr_ptr_q] <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Directed scoreboard bench for fifo_flex at DEPTH=8 and DEPTH=5.
// Each cycle updates a reference count/queue and compares all status.
module tb_fifo_flex;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_flex_if #(.WIDTH(8), .CNT_W(4)) b8 ();
  fifo_flex_if #(.WIDTH(8), .CNT_W(3)) b5 ();

  fifo_flex #(.WIDTH(8), .DEPTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .bus(b8.slave)
  );
  fifo_flex #(.WIDTH(8), .DEPTH(5)) u5 (
    .clk(clk), .rst_n(rst_n), .bus(b5.slave)
  );

  int errors = 0;
  int checks = 0;
  int m8 = 0;
  int m5 = 0;
  logic [7:0] sb8[$];
  logic [7:0] sb5[$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic stat8(string tag);
    chk({tag, ".count"}, 32'(b8.count), 32'(m8));
    chk({tag, ".f2c_irdy"}, 32'(b8.f2c_irdy), 32'(m8 > 0));
    chk({tag, ".f2p_trdy"}, 32'(b8.f2p_trdy), 32'(m8 < 8));
    chk({tag, ".af"}, 32'(b8.almost_full), 32'(m8 >= 7));
    chk({tag, ".ae"}, 32'(b8.almost_empty), 32'(m8 <= 1));
    chk({tag, ".dout"}, 32'(b8.data_out),
        (m8 > 0) ? 32'(sb8[0]) : 32'h0);
  endtask

  task automatic stat5(string tag);
    chk({tag, ".count"}, 32'(b5.count), 32'(m5));
    chk({tag, ".f2c_irdy"}, 32'(b5.f2c_irdy), 32'(m5 > 0));
    chk({tag, ".f2p_trdy"}, 32'(b5.f2p_trdy), 32'(m5 < 5));
    chk({tag, ".af"}, 32'(b5.almost_full), 32'(m5 >= 4));
    chk({tag, ".ae"}, 32'(b5.almost_empty), 32'(m5 <= 1));
    chk({tag, ".dout"}, 32'(b5.data_out),
        (m5 > 0) ? 32'(sb5[0]) : 32'h0);
  endtask

  task automatic cyc8(logic wr, logic [7:0] d, logic rd, logic fl);
    logic enq, deq;
    b8.p2f_irdy = wr;
    b8.data_in  = d;
    b8.c2f_trdy = rd;
    b8.flush    = fl;
    enq = wr && (m8 < 8);
    deq = rd && (m8 > 0);
    @(posedge clk);
    #1;
    if (fl) begin
      m8 = 0;
      sb8.delete();
    end else begin
      if (deq) void'(sb8.pop_front());
      if (enq) sb8.push_back(d);
      m8 = m8 + int'(enq) - int'(deq);
    end
    b8.p2f_irdy = 1'b0;
    b8.c2f_trdy = 1'b0;
    b8.flush    = 1'b0;
  endtask

  task automatic cyc5(logic wr, logic [7:0] d, logic rd);
    logic enq, deq;
    b5.p2f_irdy = wr;
    b5.data_in  = d;
    b5.c2f_trdy = rd;
    enq = wr && (m5 < 5);
    deq = rd && (m5 > 0);
    @(posedge clk);
    #1;
    if (deq) void'(sb5.pop_front());
    if (enq) sb5.push_back(d);
    m5 = m5 + int'(enq) - int'(deq);
    b5.p2f_irdy = 1'b0;
    b5.c2f_trdy = 1'b0;
  endtask

  initial begin
    b8.p2f_irdy = 1'b0; b8.data_in = '0;
    b8.c2f_trdy = 1'b0; b8.flush = 1'b0;
    b5.p2f_irdy = 1'b0; b5.data_in = '0;
    b5.c2f_trdy = 1'b0; b5.flush = 1'b0;
    rst_n = 1'b0;
    #12;
    stat8("rst8");
    stat5("rst5");
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 1; i <= 8; i++) begin
      cyc8(1'b1, 8'(i), 1'b0, 1'b0);
      stat8($sformatf("fill%0d", i));
    end
    cyc8(1'b1, 8'h99, 1'b0, 1'b0);
    stat8("overflow");

    for (int i = 0; i < 8; i++) begin
      cyc8(1'b0, 8'h00, 1'b1, 1'b0);
      stat8($sformatf("drain%0d", i));
    end

    for (int i = 0; i < 8; i++) begin
      cyc8(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    end
    stat8("refill");
    cyc8(1'b1, 8'hAA, 1'b1, 1'b0);
    stat8("full_both");
    cyc8(1'b1, 8'hAB, 1'b0, 1'b0);
    stat8("full_next_wr");

    for (int i = 0; i < 5; i++) begin
      cyc8(1'b0, 8'h00, 1'b1, 1'b0);
    end
    stat8("at3");

    b8.flush    = 1'b1;
    b8.p2f_irdy = 1'b1;
    b8.c2f_trdy = 1'b1;
    #1;
    chk("flush_pre.f2c_irdy", 32'(b8.f2c_irdy), 32'h1);
    chk("flush_pre.f2p_trdy", 32'(b8.f2p_trdy), 32'h1);
    chk("flush_pre.count", 32'(b8.count), 32'h3);
    cyc8(1'b1, 8'h55, 1'b1, 1'b1);
    stat8("flushed");

    cyc8(1'b1, 8'h66, 1'b0, 1'b0);
    cyc8(1'b1, 8'h67, 1'b1, 1'b0);
    stat8("prerst");
    b8.p2f_irdy = 1'b1;
    b8.data_in  = 8'h68;
    b8.c2f_trdy = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    m8 = 0;
    sb8.delete();
    stat8("async_rst");
    b8.p2f_irdy = 1'b0;
    b8.c2f_trdy = 1'b0;
    @(posedge clk);
    #1;
    stat8("rst_hold");
    rst_n = 1'b1;

    cyc5(1'b1, 8'hC0, 1'b0);
    cyc5(1'b1, 8'hC1, 1'b0);
    stat5("d5_prime");
    for (int i = 0; i < 12; i++) begin
      cyc5(1'b1, 8'hD0 + 8'(i), 1'b1);
      stat5($sformatf("d5_stream%0d", i));
    end
    for (int i = 0; i < 2; i++) begin
      cyc5(1'b0, 8'h00, 1'b1);
      stat5($sformatf("d5_drain%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
